// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states, widths and
// the hard-wired zero register.
package pipeline_hazard_ctrl_pkg;
  localparam int REG_AW      = 5;
  localparam int CNT_W       = 16;
  localparam int STALL_CNT_W = 2;
  localparam int ZERO_REG    = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } hz_state_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = pipeline_hazard_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch hazard stall, branch flush and memory-freeze control for a
// five-stage pipeline, with saturating stall and flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = pipeline_hazard_ctrl_pkg::REG_AW,
  parameter int CNT_W  = pipeline_hazard_ctrl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              branch_taken,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  import pipeline_hazard_ctrl_pkg::*;

  hz_state_e              state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   load_use, br_ex, br_mem, br_load;

  function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              uses_rt);
    return (r != REG_AW'(ZERO_REG)) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;

    load_use = ex_mem_read && reg_match(ex_rd, id_rs, id_rt, id_uses_rt);
    br_ex    = id_is_branch && ex_reg_write && reg_match(ex_rd, id_rs, id_rt, id_uses_rt);
    br_mem   = id_is_branch && mem_mem_read && reg_match(mem_rd, id_rs, id_rt, id_uses_rt);
    br_load  = id_is_branch && load_use;

    if (dmem_busy) begin
      // A freeze discards any pending stall; the hazard is re-evaluated on exit.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      state_d     = ST_FREEZE;
      stall_cnt_d = '0;
    end else if (state_q == ST_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_cnt_d  = stall_cnt_q - STALL_CNT_W'(1);
      if (stall_cnt_q <= STALL_CNT_W'(1)) state_d = ST_RUN;
    end else begin
      // RUN, or FREEZE whose release cycle behaves exactly like RUN.
      state_d     = ST_RUN;
      stall_cnt_d = '0;
      if (load_use || br_ex || br_mem) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if (br_load) begin
          state_d     = ST_STALL;
          stall_cnt_d = STALL_CNT_W'(1);
        end
      end else begin
        if_id_flush = branch_taken;
      end
    end

    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (!pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (if_id_flush),
    .count (flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios, randomized
// traffic and counter saturation against a behavioural reference model.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [AW-1:0] rs, rt, ex_rd, mem_rd;
    logic uses_rt, is_branch, ex_mem_read, ex_reg_write, mem_mem_read;
    logic branch_taken, busy, rst_n;
  } stim_t;

  typedef struct {
    logic pc, ifw, flush, bubble;
    int   sc, fc;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
  logic id_uses_rt = 0, id_is_branch = 0, ex_mem_read = 0, ex_reg_write = 0;
  logic mem_mem_read = 0, branch_taken = 0, dmem_busy = 0;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .branch_taken(branch_taken),
    .dmem_busy(dmem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state: stall cycles still owed, and counter values.
  int owed = 0;
  int m_sc = 0;
  int m_fc = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rs = '0; s.rt = '0; s.ex_rd = '0; s.mem_rd = '0;
    s.uses_rt = 0; s.is_branch = 0; s.ex_mem_read = 0; s.ex_reg_write = 0;
    s.mem_mem_read = 0; s.branch_taken = 0; s.busy = 0; s.rst_n = 1;
    return s;
  endfunction

  function automatic bit hit(input stim_t s, input logic [AW-1:0] r);
    return (r != 0) && ((r == s.rs) || (s.uses_rt && (r == s.rt)));
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit lu, any_haz;
    @(posedge clk);
    #1;
    id_rs = s.rs; id_rt = s.rt; ex_rd = s.ex_rd; mem_rd = s.mem_rd;
    id_uses_rt = s.uses_rt; id_is_branch = s.is_branch;
    ex_mem_read = s.ex_mem_read; ex_reg_write = s.ex_reg_write;
    mem_mem_read = s.mem_mem_read; branch_taken = s.branch_taken;
    dmem_busy = s.busy; rst_n = s.rst_n;
    cyc++;
    e.cyc = cyc;
    if (!s.rst_n) begin
      owed = 0; m_sc = 0; m_fc = 0;
      e.pc = 0; e.ifw = 0; e.flush = 1; e.bubble = 1;
      e.sc = 0; e.fc = 0;
      exp_q.push_back(e);
      return;
    end
    e.sc = m_sc; e.fc = m_fc;
    lu = s.ex_mem_read && hit(s, s.ex_rd);
    any_haz = lu || (s.is_branch && s.ex_reg_write && hit(s, s.ex_rd)) ||
              (s.is_branch && s.mem_mem_read && hit(s, s.mem_rd));
    if (s.busy) begin
      owed = 0;
      e.pc = 0; e.ifw = 0; e.flush = 0; e.bubble = 0;
    end else if (owed > 0) begin
      owed--;
      e.pc = 0; e.ifw = 0; e.flush = 0; e.bubble = 1;
    end else if (any_haz) begin
      owed = (s.is_branch && lu) ? 1 : 0;
      e.pc = 0; e.ifw = 0; e.flush = 0; e.bubble = 1;
    end else begin
      e.pc = 1; e.ifw = 1; e.flush = s.branch_taken; e.bubble = 0;
    end
    if (!e.pc && m_sc < CNT_MAX) m_sc++;
    if (e.flush && m_fc < CNT_MAX) m_fc++;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a response mid-cycle; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (pc_write !== e.pc || if_id_write !== e.ifw || if_id_flush !== e.flush ||
            id_ex_bubble !== e.bubble || stall_cycles !== CW'(e.sc) ||
            flush_count !== CW'(e.fc)) begin
          bad++;
          $display("FAIL cycle %0d outputs: got pc=%0b ifw=%0b flush=%0b bub=%0b sc=%0d fc=%0d, want pc=%0b ifw=%0b flush=%0b bub=%0b sc=%0d fc=%0d",
                   e.cyc, pc_write, if_id_write, if_id_flush, id_ex_bubble,
                   stall_cycles, flush_count, e.pc, e.ifw, e.flush, e.bubble, e.sc, e.fc);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    stim_t s, r;
    r = idle();
    r.rst_n = 0;
    repeat (3) step(r);

    // Load-use without branch: one stall cycle.
    s = idle(); s.ex_mem_read = 1; s.ex_rd = 3; s.rs = 3;
    step(s); step(idle()); step(idle());

    // Branch depending on a load in EX: two stall cycles.
    s = idle(); s.is_branch = 1; s.ex_mem_read = 1; s.ex_rd = 4; s.rt = 4; s.uses_rt = 1;
    step(s); step(s); step(idle());

    // Zero register never hazards.
    s = idle(); s.ex_mem_read = 1; s.ex_rd = 0; s.rs = 0;
    step(s);

    // Taken branch flushes; taken branch under load-use does not.
    s = idle(); s.branch_taken = 1; s.is_branch = 1; s.rs = 7; s.ex_rd = 2;
    step(s);
    s = idle(); s.branch_taken = 1; s.ex_mem_read = 1; s.ex_rd = 5; s.rs = 5;
    step(s); step(idle());

    // Branch vs EX ALU result and vs MEM load: single stall each.
    s = idle(); s.is_branch = 1; s.ex_reg_write = 1; s.ex_rd = 6; s.rs = 6;
    step(s);
    s = idle(); s.is_branch = 1; s.mem_mem_read = 1; s.mem_rd = 9; s.rt = 9; s.uses_rt = 1;
    step(s); step(idle());

    // Memory freeze during STALL, then hazard re-evaluated.
    s = idle(); s.is_branch = 1; s.ex_mem_read = 1; s.ex_rd = 4; s.rs = 4;
    step(s);
    s.busy = 1;
    repeat (3) step(s);
    s.busy = 0;
    step(s); step(s); step(idle()); step(idle());

    // Reset in the middle of a STALL leaves nothing pending.
    s = idle(); s.is_branch = 1; s.ex_mem_read = 1; s.ex_rd = 2; s.rs = 2;
    step(s); step(r); step(idle()); step(idle());

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rs = AW'($urandom_range(0, 3)); s.rt = AW'($urandom_range(0, 3));
      s.ex_rd = AW'($urandom_range(0, 3)); s.mem_rd = AW'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom_range(0, 1)); s.is_branch = ($urandom_range(0, 2) == 0);
      s.ex_mem_read = ($urandom_range(0, 2) == 0); s.ex_reg_write = 1'($urandom_range(0, 1));
      s.mem_mem_read = ($urandom_range(0, 2) == 0); s.branch_taken = 1'($urandom_range(0, 1));
      s.busy = ($urandom_range(0, 9) == 0); s.rst_n = ($urandom_range(0, 99) != 0);
      step(s);
    end

    // Saturation: freeze long enough to pass 0xFFFE and stay at all-ones.
    step(r);
    s = idle(); s.busy = 1;
    repeat (CNT_MAX + 3) step(s);
    drain();
    total++;
    if (stall_cycles !== CW'(CNT_MAX)) begin
      bad++;
      $display("FAIL saturate: got %0d, want %0d", stall_cycles, CNT_MAX);
    end

    // Asynchronous clear mid-cycle.
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    total++;
    if (stall_cycles !== '0 || flush_count !== '0 || pc_write !== 1'b0 ||
        if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1 || if_id_write !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got sc=%0d fc=%0d pc=%0b flush=%0b bub=%0b, want 0 0 0 1 1",
               stall_cycles, flush_count, pc_write, if_id_flush, id_ex_bubble);
    end
    step(r); step(idle()); step(idle());
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
